// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

  // Defaults shared by the UART and display FIFO instances.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 10;

  // Ceiling log2, never smaller than 1 so that a depth of 2 still gets a
  // 1-bit pointer. Used as clog2(DEPTH) for pointers and clog2(DEPTH+1) for
  // the occupancy counter.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Registered FIFO pointer: advances on inc, wraps DEPTH-1 -> 0 without any
// power-of-2 assumption, synchronous clear has priority over inc.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Pointer register with modulo-DEPTH increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
//
// Request semantics: i_wr and i_rd are single-cycle requests sampled on the
// rising edge; there is no stall. A write is accepted when there is room or a
// read is accepted in the same cycle; a read is accepted when count > 0.
// Rejected requests are dropped and recorded in o_overflow / o_underflow.
// Accepted read data appears on o_dout one clock later, qualified by a
// one-cycle o_data_ready pulse. i_clr overrides both requests.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = 8,
  parameter int AE_LVL = 2,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_data_ready,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  logic rd_ok;
  logic wr_ok;
  logic rd_acc;
  logic wr_acc;

  // Acceptance decode: a read needs data; a write needs room, or a same-cycle
  // read that frees a slot when full. Flush suppresses both.
  always_comb begin
    rd_ok  = i_rd && (count != '0);
    wr_ok  = i_wr && ((count != CNT_FULL) || rd_ok);
    rd_acc = rd_ok && !i_clr;
    wr_acc = wr_ok && !i_clr;
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wptr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_clr),
    .inc   (wr_acc),
    .ptr   (wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rptr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_clr),
    .inc   (rd_acc),
    .ptr   (rptr)
  );

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wptr] <= i_din;
  end

  // Explicit occupancy counter so all DEPTH entries are usable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read data, ready pulse and sticky error flags.
  // A same-cycle write to the slot being read cannot disturb it: mem is
  // updated at the same edge, so the read sees the old (oldest) word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dout       <= '0;
      o_data_ready <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else if (i_clr) begin
      o_data_ready <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      o_data_ready <= rd_acc;
      if (rd_acc)          o_dout      <= mem[rptr];
      if (i_wr && !wr_ok)  o_overflow  <= 1'b1;
      if (i_rd && !rd_ok)  o_underflow <= 1'b1;
    end
  end

  // Status flags decoded from the registered count.
  always_comb begin
    o_count        = count;
    o_empty        = (count == '0);
    o_full         = (count == CNT_FULL);
    o_almost_full  = (count >= CNT_W'(AF_LVL));
    o_almost_empty = (count <= CNT_W'(AE_LVL));
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit, 10-deep display/UART byte buffer.
- Adds configurable width and depth, including non-power-of-2 depth, with every entry usable.
- Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
- Sits between byte producers (UART RX, keypad scanner) and consumers (display/time-set logic) in the clock design.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 10, number of storage entries (>=2, any integer)
AF_LVL, 8, o_almost_full asserted when count >= AF_LVL (1..DEPTH)
AE_LVL, 2, o_almost_empty asserted when count <= AE_LVL (0..DEPTH-1)

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_din  in  DATA_W  write data
i_wr  in  1  write request
i_rd  in  1  read request
i_clr  in  1  synchronous flush: empties FIFO, clears sticky flags
o_dout  out  DATA_W  registered read data
o_data_ready  out  1  one-cycle pulse: o_dout updated this cycle
o_empty  out  1  count == 0
o_full  out  1  count == DEPTH
o_almost_full  out  1  count >= AF_LVL
o_almost_empty  out  1  count <= AE_LVL
o_count  out  CNT_W  occupancy, CNT_W = clog2(DEPTH+1)
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, i_rst_n=0): write pointer, read pointer and count = 0; o_dout = 0; o_data_ready = 0; o_overflow = 0; o_underflow = 0. Flags therefore read empty=1, full=0, almost_empty=1, almost_full=0. Storage contents are not reset.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0; no power-of-2 assumption.
- Occupancy is tracked by an explicit counter, not by pointer compare, so all DEPTH entries are usable.
- Status flags are combinational decodes of the registered count; they change the cycle after the causing edge.
- Write accepted when i_wr=1 and (count<DEPTH, or count==DEPTH with a read accepted the same cycle): mem[wptr] <= i_din, wptr advances.
- Write while full with no accepted read: data dropped, state unchanged, o_overflow <= 1.
- Read accepted when i_rd=1 and count>0: o_dout <= mem[rptr] next edge, rptr advances, o_data_ready <= 1 for exactly that cycle. Read latency is 1 clock.
- Read while empty: o_dout holds its previous value, o_data_ready <= 0, o_underflow <= 1.
- o_data_ready <= 0 on every cycle without an accepted read.
- Simultaneous i_wr and i_rd:
  - empty: write accepted, read rejected (no fall-through), underflow set, count -> 1.
  - full: both accepted, count stays DEPTH, no overflow.
  - otherwise: both accepted, count unchanged.
- Count update: +1 on write only, -1 on read only, unchanged for both or neither; never exceeds DEPTH, never goes below 0.
- i_clr=1 has priority over i_wr/i_rd:
  - pointers and count <= 0; o_overflow, o_underflow, o_data_ready <= 0.
  - o_dout is held.
  - any write/read in that cycle is ignored.
- Reset asserted mid-transfer aborts immediately; pending data is lost, and the first accepted write after release lands at index 0.
- Sticky flags clear only on i_clr or reset.

Decomposition:
- Shared package fifo_pkg:
  - clog2 constant function for CNT_W and pointer width (clog2(DEPTH)).
  - default DATA_W/DEPTH constants reused by the UART and display FIFO instances.
- Sub-module fifo_wrap_ptr (parameter DEPTH): registered pointer with enable, sync clear and modulo-DEPTH increment. Instanced twice, for the write and read pointers.
- Storage, counter, flags and output register stay in the top module.

Test Plan:
- Reset, then 10 writes 0x01..0x0A with DEPTH=10 -> o_full=1 after 10th edge, o_count=10, o_almost_full from 8th write; 11th write 0xFF -> dropped, o_overflow=1, o_count stays 10.
- Drain 10 reads -> o_dout sequence 0x01..0x0A, each 1 cycle after i_rd, o_data_ready high each cycle; 11th read -> o_dout holds 0x0A, o_data_ready=0, o_underflow=1.
- Wrap-around: 25 interleaved write/read pairs with occupancy 3..7 -> pointers pass index 9->0 at least twice, output order equals input order, o_count never exceeds 10.
- Simultaneous rd/wr at full (count=10) -> count stays 10, oldest word output, no overflow; at empty -> count=1, underflow=1, o_data_ready=0.
- i_clr with count=6 and i_wr=1 same cycle -> count=0, empty=1, sticky flags 0, written word not stored.
- Async reset pulse mid-burst (count=4, not clock-aligned) -> all outputs to reset values immediately; next write/read returns that new word.
